// File: rtl/coeff_sched_pkg.sv
// rtl/coeff_sched_pkg.sv - shared state encodings and defaults for the coefficient bank scheduler
package coeff_sched_pkg;

  localparam int N_TAPS_DEFAULT = 568;
  localparam int RD_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_WRITE = 2'd1,
    L_PEND  = 2'd2
  } loader_state_t;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_READ  = 2'd1,
    F_DRAIN = 2'd2
  } filter_state_t;

endpackage

// File: rtl/coeff_read_pipe.sv
// rtl/coeff_read_pipe.sv - delay line that carries tap metadata alongside the RAM read latency
module coeff_read_pipe #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_tap,
  input  logic              in_last,
  input  logic              in_bank,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_tap,
  output logic              out_last,
  output logic              out_bank
);

  localparam int W = ADDR_W + 3;

  logic [W-1:0] stage [RD_LAT];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {in_valid, in_tap, in_last, in_bank};
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign {out_valid, out_tap, out_last, out_bank} = stage[RD_LAT-1];

endmodule

// File: rtl/coeff_bank_scheduler.sv
// rtl/coeff_bank_scheduler.sv - double-buffered coefficient RAM controller between loader and FIR engine
module coeff_bank_scheduler
  import coeff_sched_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEFAULT,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  input  logic              sample_strobe,
  output logic              coef_valid,
  output logic [DATA_W-1:0] coef_data,
  output logic [ADDR_W-1:0] tap_index,
  output logic              coef_last,
  output logic              overrun,
  output logic              active_bank,
  output logic [ADDR_W-1:0] ram_addr [0:1],
  output logic              ram_we [0:1],
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q [0:1]
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);
  localparam int DW = $clog2(RD_LAT + 1);

  loader_state_t     l_state, l_next;
  filter_state_t     f_state, f_next;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DW-1:0]     drain_cnt;
  logic              strobe_pending;

  logic wr_fire, wr_last, swap_now, start_pass, rd_issue, rd_last;
  logic p_valid, p_last, p_bank;
  logic [ADDR_W-1:0] p_tap;

  assign wr_fire    = (l_state == L_WRITE) && ld_valid;
  assign wr_last    = wr_fire && (wr_addr == LAST_TAP);
  // A pending swap beats a new pass so the next pass always starts on the fresh set
  assign swap_now   = (l_state == L_PEND) && (f_state == F_IDLE);
  assign start_pass = (f_state == F_IDLE) && !swap_now && (sample_strobe || strobe_pending);
  assign rd_issue   = (f_state == F_READ);
  assign rd_last    = rd_issue && (rd_addr == LAST_TAP);

  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE:  if (ld_start) l_next = L_WRITE;
      L_WRITE: if (wr_last)  l_next = L_PEND;
      L_PEND:  if (swap_now) l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  always_comb begin
    f_next = f_state;
    case (f_state)
      F_IDLE:  if (start_pass) f_next = F_READ;
      F_READ:  if (rd_last) f_next = F_DRAIN;
      F_DRAIN: if (drain_cnt == DW'(RD_LAT - 1)) f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      l_state        <= L_IDLE;
      f_state        <= F_IDLE;
      wr_addr        <= '0;
      rd_addr        <= '0;
      drain_cnt      <= '0;
      active_bank    <= 1'b0;
      strobe_pending <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      l_state <= l_next;
      f_state <= f_next;

      if (l_state == L_IDLE && ld_start) wr_addr <= '0;
      else if (wr_fire && !wr_last)      wr_addr <= wr_addr + ADDR_W'(1);

      if (start_pass)                rd_addr <= '0;
      else if (rd_issue && !rd_last) rd_addr <= rd_addr + ADDR_W'(1);

      if (f_state == F_READ)       drain_cnt <= '0;
      else if (f_state == F_DRAIN) drain_cnt <= drain_cnt + DW'(1);

      if (swap_now) active_bank <= ~active_bank;

      if (swap_now && sample_strobe) strobe_pending <= 1'b1;
      else if (start_pass)           strobe_pending <= 1'b0;

      if (sample_strobe && f_state != F_IDLE) overrun <= 1'b1;
    end
  end

  assign ld_ready  = (l_state == L_WRITE);
  assign ld_busy   = (l_state != L_IDLE);
  assign ram_wdata = ld_ready ? ld_data : '0;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_addr[b] = '0;
      ram_we[b]   = 1'b0;
      if (b[0] == active_bank) begin
        if (rd_issue) ram_addr[b] = rd_addr;
      end else begin
        if (ld_ready) ram_addr[b] = wr_addr;
        ram_we[b] = wr_fire;
      end
    end
  end

  // The bank tag travels with each read so a swap after issue cannot corrupt in-flight data
  coeff_read_pipe #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_read_pipe (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .in_valid (rd_issue),
    .in_tap   (rd_issue ? rd_addr : '0),
    .in_last  (rd_last),
    .in_bank  (active_bank),
    .out_valid(p_valid),
    .out_tap  (p_tap),
    .out_last (p_last),
    .out_bank (p_bank)
  );

  assign coef_valid = p_valid;
  assign tap_index  = p_tap;
  assign coef_last  = p_last;
  assign coef_data  = p_valid ? ram_q[p_bank] : '0;

endmodule

// File: tb/tb_coeff_bank_scheduler.sv
// tb/tb_coeff_bank_scheduler.sv - directed self-checking bench for coeff_bank_scheduler
module tb_coeff_bank_scheduler;

  localparam int NT = 568;

  logic        CLOCK_50 = 1'b0;
  logic        reset, ld_start, ld_valid, sample_strobe, preload;
  logic [15:0] ld_data;
  logic        ld_ready, ld_busy, coef_valid, coef_last, overrun, active_bank;
  logic [15:0] coef_data, ram_wdata;
  logic [9:0]  tap_index;
  logic [9:0]  ram_addr [0:1];
  logic        ram_we [0:1];
  logic [15:0] ram_q [0:1];

  logic [15:0] mem [0:1][0:1023];
  logic [9:0]  addr_q [0:1];

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_we1;
    logic [9:0]  exp_addr1;
  } ld_vec_t;

  ld_vec_t vecs [7];

  always #10 CLOCK_50 = ~CLOCK_50;

  coeff_bank_scheduler dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_busy      (ld_busy),
    .sample_strobe(sample_strobe),
    .coef_valid   (coef_valid),
    .coef_data    (coef_data),
    .tap_index    (tap_index),
    .coef_last    (coef_last),
    .overrun      (overrun),
    .active_bank  (active_bank),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_q        (ram_q)
  );

  // Two registered stages: address register, then output register
  always @(posedge CLOCK_50) begin
    if (preload) begin
      for (int k = 0; k < 1024; k++) begin
        mem[0][k] <= 16'h1000 + 16'(k);
        mem[1][k] <= 16'h2000 + 16'(k);
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (ram_we[b]) mem[b][ram_addr[b]] <= ram_wdata;
        addr_q[b] <= ram_addr[b];
        ram_q[b]  <= mem[b][addr_q[b]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Caller raises sample_strobe at the current negedge; latency counts cycles after that one
  task automatic check_pass(input int exp_lat, input logic [15:0] base, input string name);
    int lat;
    int bad;
    @(negedge CLOCK_50);
    sample_strobe = 1'b0;
    lat = 1;
    while (!coef_valid && lat < 20) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    bad = 0;
    for (int i = 0; i < NT; i++) begin
      if (i > 0) @(negedge CLOCK_50);
      if (coef_valid !== 1'b1 || tap_index !== 10'(i) || coef_data !== 16'(base + 16'(i)) ||
          coef_last !== (i == NT - 1)) begin
        if (bad == 0)
          $display("  %s first bad tap %0d: valid %0b tap %0d data %0h last %0b", name, i,
                   coef_valid, tap_index, coef_data, coef_last);
        bad++;
      end
    end
    check({name, " bad taps"}, bad, 0);
    @(negedge CLOCK_50);
    check({name, " pass end"}, coef_valid, 1'b0);
  endtask

  task automatic load_words(input logic [15:0] base, input int bank, input string name);
    for (int k = 0; k < NT; k++) begin
      @(negedge CLOCK_50);
      ld_start = 1'b0;
      ld_valid = 1'b1;
      ld_data  = base + 16'(k);
      if (k == 0) begin
        #1;
        check({name, " first write at addr 0"}, {ram_we[bank], ram_addr[bank]}, {1'b1, 10'd0});
      end
    end
    @(negedge CLOCK_50);
    ld_valid = 1'b0;
    ld_data  = '0;
    #1;
    check({name, " ready drops"}, ld_ready, 1'b0);
  endtask

  task automatic load_set(input logic [15:0] base, input int bank, input string name);
    @(negedge CLOCK_50);
    ld_start = 1'b1;
    load_words(base, bank, name);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    ld_start = 1'b0; ld_valid = 1'b0; sample_strobe = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[1] = '{1'b0, 1'b1, 16'hA000, 1'b1, 1'b1, 1'b1, 10'd0};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 10'd1};
    vecs[3] = '{1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 1'b1, 10'd1};
    vecs[4] = '{1'b1, 1'b1, 16'hA002, 1'b1, 1'b1, 1'b1, 10'd2};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 10'd3};
    vecs[6] = '{1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b1, 10'd3};

    preload = 1'b1; reset = 1'b1;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; sample_strobe = 1'b0;
    @(negedge CLOCK_50);
    preload = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("reset coef", {coef_valid, coef_data, tap_index, coef_last}, '0);
    check("reset flags", {overrun, active_bank, ld_ready, ld_busy}, 4'b0);
    check("reset ram ports", {ram_we[0], ram_we[1], ram_addr[0], ram_addr[1], ram_wdata}, '0);
    reset = 1'b0;

    // plain pass on bank 0 after reset
    @(negedge CLOCK_50);
    sample_strobe = 1'b1;
    check_pass(3, 16'h1000, "t1");

    // loader handshake vectors, then abort a partial load with reset
    for (int i = 0; i < 7; i++) begin
      @(negedge CLOCK_50);
      ld_start = vecs[i].start;
      ld_valid = vecs[i].valid;
      ld_data  = vecs[i].data;
      #1;
      check($sformatf("vec%0d ports", i),
            {ld_ready, ld_busy, ram_we[1], ram_addr[1], ram_we[0], ram_addr[0]},
            {vecs[i].exp_ready, vecs[i].exp_busy, vecs[i].exp_we1, vecs[i].exp_addr1, 1'b0, 10'd0});
      if (vecs[i].exp_we1) check($sformatf("vec%0d wdata", i), ram_wdata, vecs[i].data);
    end
    for (int k = 4; k < 300; k++) begin
      @(negedge CLOCK_50);
      ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'hA000 + 16'(k);
    end
    @(negedge CLOCK_50);
    ld_valid = 1'b0; ld_data = '0; reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("t6 after reset busy/bank", {ld_busy, ld_ready, active_bank}, 3'b000);
    bad = 0;
    for (int k = 0; k < 300; k++) if (mem[1][k] !== 16'hA000 + 16'(k)) bad++;
    if (mem[1][300] !== 16'h2000 + 16'd300) bad++;
    check("t6 partial contents", bad, 0);

    // full load into bank 1 restarting at addr 0, then swap
    load_set(16'h0100, 1, "t2");
    check("t2 pend state", {ld_busy, active_bank}, 2'b10);
    @(negedge CLOCK_50);
    check("t2 swapped", {ld_busy, active_bank}, 2'b01);
    bad = 0;
    for (int k = 0; k < NT; k++) if (mem[1][k] !== 16'h0100 + 16'(k)) bad++;
    check("t2 bank1 contents", bad, 0);

    // overrun: second strobe mid-pass is dropped
    @(negedge CLOCK_50);
    sample_strobe = 1'b1;
    fork
      check_pass(3, 16'h0100, "t5");
      begin
        n = 0;
        while (!(coef_valid && tap_index == 10'd100) && n < 700) begin
          @(negedge CLOCK_50);
          n++;
        end
        sample_strobe = 1'b1;
        @(negedge CLOCK_50);
        sample_strobe = 1'b0;
        #1;
        check("t5 overrun set", overrun, 1'b1);
      end
    join
    n = 0;
    repeat (12) begin
      @(negedge CLOCK_50);
      if (coef_valid) n++;
    end
    check("t5 no extra pass", n, 0);
    check("t5 overrun sticky", overrun, 1'b1);

    // load finishes while a pass runs: swap waits for the filter to go idle
    do_reset();
    check("t3 reset clears", {overrun, active_bank}, 2'b00);
    @(negedge CLOCK_50);
    sample_strobe = 1'b1;
    ld_start = 1'b1;
    fork
      check_pass(3, 16'h1000, "t3a");
      begin
        load_words(16'h0300, 1, "t3 load");
        check("t3 swap deferred", {ld_busy, active_bank}, 2'b10);
      end
    join
    n = 0;
    while (!active_bank && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("t3 swapped after pass", active_bank, 1'b1);
    @(negedge CLOCK_50);
    sample_strobe = 1'b1;
    check_pass(3, 16'h0300, "t3b");

    // swap and strobe in the same cycle
    load_set(16'h0400, 0, "t4");
    sample_strobe = 1'b1;
    @(negedge CLOCK_50);
    sample_strobe = 1'b0;
    check("t4 swap wins", {active_bank, ld_busy, coef_valid}, 3'b000);
    check_pass(3, 16'h0400, "t4");
    check("t4 no overrun", overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
